// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its write/read arbiter.
// Opcode/operand/address types, stored instruction layout, sweep FSM states.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic {
        RD_IDLE,
        RD_SWEEP
    } rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
// Ports: clk, reset, clear, req[N], advance -> gnt[N] (one-hot), gnt_idx.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_prio;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // Scan requesters starting at the priority pointer; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = IW'((int'(r_prio) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_prio <= '0;
        end else if (advance) begin
            r_prio <= IW'((int'(gnt_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/instr_reg_write_arbiter.sv
// Shares instr_register's write port between NUM_REQ sources (round robin,
// auto slot allocation) and sweeps its read port over all written slots.
// Ports: req_* in / req_ready out (one-hot grant); load_en, write_pointer,
//   opcode, operand_a/b, grant_id registered write beat; rd_start in,
//   read_pointer/rd_strobe/rd_done sweep outputs; count, full status.
module instr_reg_write_arbiter
    import instr_register_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 32,
    parameter int WRAP_EN = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  opcode_t                    req_opcode [NUM_REQ],
    input  operand_t                   req_op_a   [NUM_REQ],
    input  operand_t                   req_op_b   [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       load_en,
    output address_t                   write_pointer,
    output opcode_t                    opcode,
    output operand_t                   operand_a,
    output operand_t                   operand_b,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output address_t                   read_pointer,
    input  logic                       rd_start,
    output logic                       rd_strobe,
    output logic                       rd_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               w_open;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [GW-1:0]      w_idx;
    logic               w_accept;

    address_t           r_wr_ptr;
    logic [CW-1:0]      r_count;
    rd_state_t          r_state;
    address_t           r_last;

    assign full   = (r_count == CW'(DEPTH)) && (WRAP_EN == 0);
    assign count  = r_count;

    // Requests are masked before arbitration so a blocked cycle grants nothing
    // and the priority pointer does not move.
    assign w_open = !full && !clear && !reset;
    assign w_req  = req_valid & {NUM_REQ{w_open}};

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .req     (w_req),
        .advance (w_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_idx)
    );

    assign w_accept  = |w_gnt;
    assign req_ready = w_gnt;

    // Write beat register stage and slot allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en       <= 1'b0;
            write_pointer <= '0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            grant_id      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (clear) begin
            load_en  <= 1'b0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            load_en <= w_accept;
            if (w_accept) begin
                write_pointer <= r_wr_ptr;
                opcode        <= req_opcode[w_idx];
                operand_a     <= req_op_a[w_idx];
                operand_b     <= req_op_b[w_idx];
                grant_id      <= w_idx;
                r_wr_ptr      <= (r_wr_ptr == address_t'(DEPTH - 1))
                                 ? '0 : r_wr_ptr + address_t'(1);
                if (r_count != CW'(DEPTH)) begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    // Sweep sequencer: rd_done coincides with the final strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RD_IDLE;
            r_last       <= '0;
            read_pointer <= '0;
            rd_strobe    <= 1'b0;
            rd_done      <= 1'b0;
        end else if (clear) begin
            r_state   <= RD_IDLE;
            rd_strobe <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            unique case (r_state)
                RD_IDLE: begin
                    rd_strobe <= 1'b0;
                    rd_done   <= 1'b0;
                    if (rd_start) begin
                        if (r_count != '0) begin
                            r_last       <= address_t'(r_count - CW'(1));
                            read_pointer <= '0;
                            rd_strobe    <= 1'b1;
                            rd_done      <= (r_count == CW'(1));
                            r_state      <= RD_SWEEP;
                        end else begin
                            rd_done <= 1'b1;
                        end
                    end
                end
                RD_SWEEP: begin
                    if (read_pointer == r_last) begin
                        rd_strobe <= 1'b0;
                        rd_done   <= 1'b0;
                        r_state   <= RD_IDLE;
                    end else begin
                        read_pointer <= read_pointer + address_t'(1);
                        rd_strobe    <= 1'b1;
                        rd_done      <= (read_pointer + address_t'(1) == r_last);
                    end
                end
                default: begin
                    r_state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_reg_write_arbiter.sv
// Directed bench for instr_reg_write_arbiter: one stalling and one wrapping
// instance share stimulus; a small register model captures load_en beats.
module tb_instr_reg_write_arbiter;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       clear;
    logic       rd_start;
    logic [1:0] req_valid;
    opcode_t    req_opcode [2];
    operand_t   req_op_a   [2];
    operand_t   req_op_b   [2];

    logic [1:0] ready,   ready_w;
    logic       load_en, load_w;
    address_t   wp,      wp_w;
    opcode_t    opc,     opc_w;
    operand_t   oa,      oa_w;
    operand_t   ob,      ob_w;
    logic       gid,     gid_w;
    address_t   rp,      rp_w;
    logic       strobe,  strobe_w;
    logic       done,    done_w;
    logic [5:0] cnt,     cnt_w;
    logic       full,    full_w;

    instr_reg_write_arbiter #(
        .NUM_REQ (2),
        .DEPTH   (32),
        .WRAP_EN (0)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_opcode    (req_opcode),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .req_ready     (ready),
        .load_en       (load_en),
        .write_pointer (wp),
        .opcode        (opc),
        .operand_a     (oa),
        .operand_b     (ob),
        .grant_id      (gid),
        .read_pointer  (rp),
        .rd_start      (rd_start),
        .rd_strobe     (strobe),
        .rd_done       (done),
        .count         (cnt),
        .full          (full)
    );

    instr_reg_write_arbiter #(
        .NUM_REQ (2),
        .DEPTH   (32),
        .WRAP_EN (1)
    ) u_dut_w (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_opcode    (req_opcode),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .req_ready     (ready_w),
        .load_en       (load_w),
        .write_pointer (wp_w),
        .opcode        (opc_w),
        .operand_a     (oa_w),
        .operand_b     (ob_w),
        .grant_id      (gid_w),
        .read_pointer  (rp_w),
        .rd_start      (rd_start),
        .rd_strobe     (strobe_w),
        .rd_done       (done_w),
        .count         (cnt_w),
        .full          (full_w)
    );

    // Model of instr_register storage behind the stalling instance.
    instruction_t mem [32];
    always @(posedge clk) begin
        if (load_en) mem[wp] <= {opc, oa, ob};
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        rd_start  = 1'b0;
        req_valid = 2'b11;
        for (int j = 0; j < 2; j++) begin
            req_opcode[j] = ZERO;
            req_op_a[j]   = '0;
            req_op_b[j]   = '0;
        end

        // Reset
        tick();
        chk("rst_ready", ready, 0);
        tick();
        reset     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rst_load_en", load_en, 0);
        chk("rst_wp", wp, 0);
        chk("rst_opa", oa, 0);
        chk("rst_gid", gid, 0);
        chk("rst_count", cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_done", done, 0);
        chk("rst_rp", rp, 0);

        // Both requesters valid: alternate grants, sequential slots
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b11;
            for (int j = 0; j < 2; j++) begin
                req_opcode[j] = (j == 0) ? ADD : SUB;
                req_op_a[j]   = 100 * j + k;
                req_op_b[j]   = 50 + 100 * j + k;
            end
            #1;
            chk("rr_ready", ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            chk("rr_load_en", load_en, 1);
            chk("rr_wp", wp, k);
            chk("rr_gid", gid, k % 2);
            chk("rr_opa", oa, 100 * (k % 2) + k);
            chk("rr_opc", opc, (k % 2 == 1) ? SUB : ADD);
        end
        req_valid = 2'b00;
        tick();
        chk("idle_load_en", load_en, 0);
        chk("idle_wp_hold", wp, 3);
        chk("idle_count", cnt, 4);

        // Clear blocks the accept in its own cycle
        req_valid = 2'b11;
        clear     = 1'b1;
        #1;
        chk("clear_ready", ready, 0);
        tick();
        clear     = 1'b0;
        req_valid = 2'b00;
        chk("clear_load_en", load_en, 0);
        chk("clear_count", cnt, 0);

        // Three writes from requester 1 only, then sweep
        for (int k = 0; k < 3; k++) begin
            req_valid     = 2'b10;
            req_opcode[1] = MULT;
            req_op_a[1]   = 200 + k;
            req_op_b[1]   = 300 + k;
            #1;
            chk("w3_ready", ready, 2'b10);
            tick();
            chk("w3_gid", gid, 1);
            chk("w3_wp", wp, k);
        end
        req_valid = 2'b00;
        tick();
        chk("w3_count", cnt, 3);

        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("sw_strobe", strobe, 1);
            chk("sw_rp", rp, k);
            chk("sw_done", done, (k == 2) ? 1 : 0);
            chk("sw_opa", mem[rp].op_a, 200 + k);
            chk("sw_opb", mem[rp].op_b, 300 + k);
            chk("sw_opc", mem[rp].opc, MULT);
            rd_start = (k == 1);
            tick();
        end
        rd_start = 1'b0;
        chk("sw_end_strobe", strobe, 0);
        chk("sw_end_done", done, 0);
        chk("sw_rp_hold", rp, 2);
        tick();
        chk("sw_restart_ignored", strobe, 0);

        // Clear in sweep cycle 2 aborts without rd_done
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("ab_c1_strobe", strobe, 1);
        chk("ab_c1_rp", rp, 0);
        tick();
        chk("ab_c2_rp", rp, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ab_strobe", strobe, 0);
        chk("ab_done", done, 0);
        chk("ab_rp_hold", rp, 1);
        chk("ab_count", cnt, 0);
        tick();
        chk("ab_done_after", done, 0);
        chk("ab_strobe_after", strobe, 0);

        // Sweep request with nothing written
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_strobe", strobe, 0);
        tick();
        chk("empty_done_pulse", done, 0);
        chk("empty_strobe2", strobe, 0);

        // Fill: stalling instance goes full, wrapping one overwrites slot 0
        req_valid = 2'b11;
        for (int i = 0; i < 32; i++) begin
            tick();
        end
        chk("fill_last_wp", wp, 31);
        chk("fill_last_load", load_en, 1);
        chk("fill_count", cnt, 32);
        chk("fill_full", full, 1);
        chk("fill_ready", ready, 0);
        chk("wrap_ready", ready_w, 2'b01);
        tick();
        chk("full_no_load", load_en, 0);
        chk("full_count", cnt, 32);
        chk("full_wp_hold", wp, 31);
        chk("wrap_load", load_w, 1);
        chk("wrap_wp", wp_w, 0);
        chk("wrap_count", cnt_w, 32);
        chk("wrap_full", full_w, 0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("fclr_count", cnt, 0);
        chk("fclr_full", full, 0);
        tick();
        chk("fclr_restart_load", load_en, 1);
        chk("fclr_restart_wp", wp, 0);
        req_valid = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
